// File: rtl/cv32e40s_rf_ecc_scrubber.sv
// Background ECC scrubber for the register file: walks x1..x31 on a borrowed
// read port during idle cycles and reports words whose check bits do not match.
module cv32e40s_rf_ecc_scrubber #(
  parameter int unsigned SCRUB_INTERVAL          = 64,
  parameter int unsigned ERR_CNT_WIDTH           = 8,
  parameter int unsigned REGFILE_NUM_WRITE_PORTS = 2,
  parameter int unsigned REGFILE_WORD_WIDTH      = 38
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     enable_i,
  input  logic                                     port_free_i,
  output logic                                     rd_req_o,
  output logic [4:0]                               raddr_o,
  input  logic [REGFILE_WORD_WIDTH-1:0]            rdata_i,
  input  logic [REGFILE_NUM_WRITE_PORTS-1:0][4:0]  waddr_i,
  input  logic [REGFILE_NUM_WRITE_PORTS-1:0]       we_i,
  input  logic                                     clear_i,
  output logic                                     err_o,
  output logic [4:0]                               err_addr_o,
  output logic [ERR_CNT_WIDTH-1:0]                 err_cnt_o
);

  localparam int          ECC_WIDTH = REGFILE_WORD_WIDTH - 32;
  localparam logic [15:0] RELOAD    = 16'(SCRUB_INTERVAL - 1);

  // Parity masks shared with the register file write-side encoder.
  localparam logic [5:0][31:0] ECC_MASK = {
    32'h2DCC624C, 32'hC2C1323B, 32'h31234ED1,
    32'h413D89AA, 32'hDEBA8050, 32'h2606BD25
  };

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REQ,
    CHECK
  } state_e;

  state_e                          state_q, state_d;
  logic [15:0]                     cnt_q, cnt_d;
  logic [4:0]                      ptr_q, ptr_d;
  logic [REGFILE_WORD_WIDTH-1:0]   word_q, word_d;
  logic                            coll_q, coll_d;
  logic                            err_q, err_d;
  logic [4:0]                      err_addr_q, err_addr_d;
  logic [ERR_CNT_WIDTH-1:0]        err_cnt_q, err_cnt_d;

  logic                            collision_now;
  logic                            mismatch;
  logic [4:0]                      ptr_next;

  function automatic logic [ECC_WIDTH-1:0] ecc_encode(input logic [31:0] data);
    logic [ECC_WIDTH-1:0] chk;
    chk = '0;
    for (int i = 0; i < ECC_WIDTH; i++) begin
      chk[i] = ^(data & ECC_MASK[i]);
    end
    return chk;
  endfunction

  always_comb begin
    collision_now = 1'b0;
    for (int k = 0; k < int'(REGFILE_NUM_WRITE_PORTS); k++) begin
      if (we_i[k] && (waddr_i[k] == ptr_q)) begin
        collision_now = 1'b1;
      end
    end
  end

  assign mismatch = (ecc_encode(word_q[31:0]) != word_q[REGFILE_WORD_WIDTH-1:32]);
  assign ptr_next = (ptr_q == 5'd31) ? 5'd1 : ptr_q + 5'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    word_d     = word_q;
    coll_d     = coll_q;
    err_d      = 1'b0;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      IDLE: begin
        cnt_d = RELOAD;
        if (enable_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 16'd0) begin
          state_d = REQ;
          cnt_d   = RELOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      REQ: begin
        if (port_free_i) begin
          word_d  = rdata_i;
          coll_d  = collision_now;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = WAIT;
        // A write to the scrubbed address makes the sample stale: retry it later.
        if (!(coll_q || collision_now)) begin
          ptr_d = ptr_next;
          if (mismatch) begin
            err_d      = 1'b1;
            err_addr_d = ptr_q;
            if (err_cnt_q != {ERR_CNT_WIDTH{1'b1}}) begin
              err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable_i) begin
      state_d    = IDLE;
      ptr_d      = ptr_q;
      err_d      = 1'b0;
      err_addr_d = err_addr_q;
      err_cnt_d  = err_cnt_q;
    end

    if (clear_i) begin
      err_cnt_d  = '0;
      err_addr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= RELOAD;
      ptr_q      <= 5'd1;
      word_q     <= '0;
      coll_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      word_q     <= word_d;
      coll_q     <= coll_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign rd_req_o   = (state_q == REQ);
  assign raddr_o    = ptr_q;
  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_cv32e40s_rf_ecc_scrubber.sv
// Self-checking bench for cv32e40s_rf_ecc_scrubber: models the register file
// contents and predicts each scrub outcome through a scoreboard queue.
module tb_cv32e40s_rf_ecc_scrubber;

  logic             clk;
  logic             rst_n;
  logic             enable_i;
  logic             port_free_i;
  logic             rd_req_o;
  logic [4:0]       raddr_o;
  logic [37:0]      rdata_i;
  logic [1:0][4:0]  waddr_i;
  logic [1:0]       we_i;
  logic             clear_i;
  logic             err_o;
  logic [4:0]       err_addr_o;
  logic [1:0]       err_cnt_o;

  logic [37:0]      rf [32];

  typedef struct {
    bit         err;
    logic [4:0] addr;
  } exp_t;

  exp_t       sb[$];
  int         total;
  int         passed;
  int         cyc;
  logic [1:0] exp_cnt;

  cv32e40s_rf_ecc_scrubber #(
    .SCRUB_INTERVAL          (4),
    .ERR_CNT_WIDTH           (2),
    .REGFILE_NUM_WRITE_PORTS (2),
    .REGFILE_WORD_WIDTH      (38)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable_i),
    .port_free_i (port_free_i),
    .rd_req_o    (rd_req_o),
    .raddr_o     (raddr_o),
    .rdata_i     (rdata_i),
    .waddr_i     (waddr_i),
    .we_i        (we_i),
    .clear_i     (clear_i),
    .err_o       (err_o),
    .err_addr_o  (err_addr_o),
    .err_cnt_o   (err_cnt_o)
  );

  assign rdata_i = rf[raddr_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference encoder for a clean register file word {check, data}.
  function automatic logic [37:0] enc(input logic [31:0] d);
    logic [31:0] m;
    logic [5:0]  c;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       m = 32'h2606BD25;
        1:       m = 32'hDEBA8050;
        2:       m = 32'h413D89AA;
        3:       m = 32'h31234ED1;
        4:       m = 32'hC2C1323B;
        default: m = 32'h2DCC624C;
      endcase
      c[i] = ^(d & m);
    end
    return {c, d};
  endfunction

  // Waits for a granted read and pushes the predicted outcome of that scrub.
  task automatic wait_grant(input bit stale, output logic [4:0] addr, output bit ok);
    exp_t e;
    ok   = 1'b0;
    addr = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rd_req_o && port_free_i) begin
        ok   = 1'b1;
        addr = raddr_o;
        break;
      end
    end
    if (ok) begin
      e.err  = !stale && (rf[addr] !== enc(rf[addr][31:0]));
      e.addr = addr;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    enable_i    = 1'b0;
    port_free_i = 1'b0;
    waddr_i     = '0;
    we_i        = '0;
    clear_i     = 1'b0;
    exp_cnt     = '0;
    for (int i = 0; i < 32; i++) rf[i] = enc($urandom);
    repeat (3) @(negedge clk);
    total++; if (rd_req_o !== 1'b0) $display("[TB] FAIL reset_rd_req: got %0b want 0", rd_req_o); else passed++;
    total++; if (raddr_o !== 5'd1) $display("[TB] FAIL reset_raddr: got %0d want 1", raddr_o); else passed++;
    total++; if (err_o !== 1'b0) $display("[TB] FAIL reset_err: got %0b want 0", err_o); else passed++;
    total++; if (err_addr_o !== 5'd0) $display("[TB] FAIL reset_err_addr: got %0d want 0", err_addr_o); else passed++;
    total++; if (err_cnt_o !== 2'd0) $display("[TB] FAIL reset_err_cnt: got %0d want 0", err_cnt_o); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_clean_walk;
    logic [4:0] a;
    logic [4:0] exp_addr;
    bit         ok;
    exp_t       e;
    int         last;
    enable_i    = 1'b1;
    port_free_i = 1'b1;
    exp_addr    = 5'd1;
    last        = -1;
    for (int n = 0; n < 32; n++) begin
      wait_grant(1'b0, a, ok);
      total++;
      if (!ok) begin
        $display("[TB] FAIL walk_timeout: no grant, want addr %0d", exp_addr);
        return;
      end
      passed++;
      total++; if (a !== exp_addr) $display("[TB] FAIL walk_addr: got %0d want %0d", a, exp_addr); else passed++;
      if (last >= 0) begin
        total++; if (cyc - last !== 6) $display("[TB] FAIL walk_period: got %0d want 6", cyc - last); else passed++;
      end
      last     = cyc;
      exp_addr = (exp_addr == 5'd31) ? 5'd1 : exp_addr + 5'd1;
      @(negedge clk);
      @(negedge clk);
      e = sb.pop_front();
      total++; if (err_o !== e.err) $display("[TB] FAIL walk_err: addr %0d got %0b want %0b", e.addr, err_o, e.err); else passed++;
    end
    total++; if (err_cnt_o !== exp_cnt) $display("[TB] FAIL walk_cnt: got %0d want %0d", err_cnt_o, exp_cnt); else passed++;
  endtask

  task automatic test_corrupt_x5;
    logic [4:0] a;
    bit         ok;
    exp_t       e;
    rf[5][32] = ~rf[5][32];
    for (int n = 2; n <= 6; n++) begin
      wait_grant(1'b0, a, ok);
      total++;
      if (!ok) begin
        $display("[TB] FAIL x5_timeout: no grant, want addr %0d", n);
        return;
      end
      passed++;
      total++; if (a !== 5'(n)) $display("[TB] FAIL x5_addr: got %0d want %0d", a, n); else passed++;
      @(negedge clk);
      @(negedge clk);
      e = sb.pop_front();
      total++; if (err_o !== e.err) $display("[TB] FAIL x5_err: addr %0d got %0b want %0b", e.addr, err_o, e.err); else passed++;
      if (e.err) begin
        if (exp_cnt != 2'd3) exp_cnt++;
        total++; if (err_addr_o !== e.addr) $display("[TB] FAIL x5_err_addr: got %0d want %0d", err_addr_o, e.addr); else passed++;
        total++; if (err_cnt_o !== exp_cnt) $display("[TB] FAIL x5_err_cnt: got %0d want %0d", err_cnt_o, exp_cnt); else passed++;
      end
    end
    total++; if (err_addr_o !== 5'd5) $display("[TB] FAIL x5_sticky_addr: got %0d want 5", err_addr_o); else passed++;
    total++; if (err_cnt_o !== 2'd1) $display("[TB] FAIL x5_final_cnt: got %0d want 1", err_cnt_o); else passed++;
    rf[5] = enc(rf[5][31:0]);
  endtask

  task automatic test_port_busy;
    logic [4:0] a;
    bit         ok;
    exp_t       e;
    int         grant_cyc;
    port_free_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rd_req_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (!ok) $display("[TB] FAIL busy_req_timeout: rd_req_o got 0 want 1"); else passed++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (rd_req_o !== 1'b1 || raddr_o !== 5'd7)
        $display("[TB] FAIL busy_hold: rd_req %0b raddr %0d want 1 / 7", rd_req_o, raddr_o); else passed++;
    end
    port_free_i = 1'b1;
    grant_cyc   = cyc;
    e.err  = (rf[7] !== enc(rf[7][31:0]));
    e.addr = 5'd7;
    sb.push_back(e);
    @(negedge clk);
    total++; if (rd_req_o !== 1'b0) $display("[TB] FAIL busy_single_grant: rd_req got %0b want 0", rd_req_o); else passed++;
    @(negedge clk);
    e = sb.pop_front();
    total++; if (err_o !== e.err) $display("[TB] FAIL busy_err: got %0b want %0b", err_o, e.err); else passed++;
    wait_grant(1'b0, a, ok);
    total++; if (!ok || a !== 5'd8) $display("[TB] FAIL busy_next_addr: got %0d want 8", a); else passed++;
    total++; if (cyc - grant_cyc !== 6) $display("[TB] FAIL busy_next_period: got %0d want 6", cyc - grant_cyc); else passed++;
    @(negedge clk);
    @(negedge clk);
    if (ok) e = sb.pop_front();
    total++; if (err_o !== 1'b0) $display("[TB] FAIL busy_next_err: got %0b want 0", err_o); else passed++;
  endtask

  task automatic test_collision;
    logic [4:0] a;
    bit         ok;
    exp_t       e;
    rf[9][32] = ~rf[9][32];
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_req_o) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok || raddr_o !== 5'd9) $display("[TB] FAIL coll_grant: raddr got %0d want 9", raddr_o); else passed++;
    we_i[0]    = 1'b1;
    waddr_i[0] = 5'd9;
    e.err  = 1'b0;
    e.addr = 5'd9;
    sb.push_back(e);
    @(negedge clk);
    we_i[0]    = 1'b0;
    waddr_i[0] = 5'd0;
    rf[9]      = enc(32'hCAFE_0009);
    @(negedge clk);
    e = sb.pop_front();
    total++; if (err_o !== e.err) $display("[TB] FAIL coll_err: got %0b want %0b", err_o, e.err); else passed++;
    total++; if (raddr_o !== 5'd9) $display("[TB] FAIL coll_ptr_hold: got %0d want 9", raddr_o); else passed++;
    wait_grant(1'b0, a, ok);
    total++; if (!ok || a !== 5'd9) $display("[TB] FAIL coll_reread: got %0d want 9", a); else passed++;
    @(negedge clk);
    @(negedge clk);
    if (ok) e = sb.pop_front();
    total++; if (err_o !== 1'b0) $display("[TB] FAIL coll_reread_err: got %0b want 0", err_o); else passed++;
  endtask

  task automatic test_saturation;
    logic [4:0] a;
    bit         ok;
    exp_t       e;
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    exp_cnt = '0;
    total++; if (err_cnt_o !== 2'd0 || err_addr_o !== 5'd0)
      $display("[TB] FAIL sat_clear: cnt %0d addr %0d want 0 / 0", err_cnt_o, err_addr_o); else passed++;
    for (int r = 10; r <= 15; r++) rf[r][32] = ~rf[r][32];
    for (int n = 10; n <= 14; n++) begin
      wait_grant(1'b0, a, ok);
      total++;
      if (!ok) begin
        $display("[TB] FAIL sat_timeout: no grant, want addr %0d", n);
        return;
      end
      passed++;
      total++; if (a !== 5'(n)) $display("[TB] FAIL sat_addr: got %0d want %0d", a, n); else passed++;
      @(negedge clk);
      @(negedge clk);
      e = sb.pop_front();
      if (e.err && exp_cnt != 2'd3) exp_cnt++;
      total++; if (err_o !== e.err) $display("[TB] FAIL sat_err: addr %0d got %0b want %0b", e.addr, err_o, e.err); else passed++;
      total++; if (err_cnt_o !== exp_cnt) $display("[TB] FAIL sat_cnt: got %0d want %0d", err_cnt_o, exp_cnt); else passed++;
      total++; if (err_addr_o !== e.addr) $display("[TB] FAIL sat_err_addr: got %0d want %0d", err_addr_o, e.addr); else passed++;
    end
    total++; if (err_cnt_o !== 2'd3) $display("[TB] FAIL sat_final: got %0d want 3", err_cnt_o); else passed++;
    wait_grant(1'b0, a, ok);
    total++; if (!ok || a !== 5'd15) $display("[TB] FAIL sat_clr_addr: got %0d want 15", a); else passed++;
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    if (ok) e = sb.pop_front();
    exp_cnt = '0;
    total++; if (err_o !== 1'b1) $display("[TB] FAIL sat_clr_pulse: got %0b want 1", err_o); else passed++;
    total++; if (err_cnt_o !== 2'd0) $display("[TB] FAIL sat_clr_cnt: got %0d want 0", err_cnt_o); else passed++;
    total++; if (err_addr_o !== 5'd0) $display("[TB] FAIL sat_clr_addr_reg: got %0d want 0", err_addr_o); else passed++;
    for (int r = 10; r <= 15; r++) rf[r] = enc(rf[r][31:0]);
  endtask

  task automatic test_disable_in_check;
    logic [4:0] a;
    bit         ok;
    exp_t       e;
    rf[16][32] = ~rf[16][32];
    wait_grant(1'b1, a, ok);
    total++; if (!ok || a !== 5'd16) $display("[TB] FAIL dis_grant: got %0d want 16", a); else passed++;
    @(negedge clk);
    enable_i = 1'b0;
    @(negedge clk);
    if (ok) e = sb.pop_front();
    total++; if (err_o !== 1'b0) $display("[TB] FAIL dis_err: got %0b want 0", err_o); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (rd_req_o !== 1'b0 || raddr_o !== 5'd16 || err_cnt_o !== exp_cnt)
        $display("[TB] FAIL dis_idle: rd_req %0b raddr %0d cnt %0d want 0 / 16 / %0d", rd_req_o, raddr_o, err_cnt_o, exp_cnt);
      else passed++;
    end
    enable_i = 1'b1;
    wait_grant(1'b0, a, ok);
    total++; if (!ok || a !== 5'd16) $display("[TB] FAIL dis_resume_addr: got %0d want 16", a); else passed++;
    @(negedge clk);
    @(negedge clk);
    if (ok) begin
      e = sb.pop_front();
      if (e.err && exp_cnt != 2'd3) exp_cnt++;
    end
    total++; if (err_o !== 1'b1) $display("[TB] FAIL dis_resume_err: got %0b want 1", err_o); else passed++;
    total++; if (err_addr_o !== 5'd16) $display("[TB] FAIL dis_resume_err_addr: got %0d want 16", err_addr_o); else passed++;
    total++; if (err_cnt_o !== exp_cnt) $display("[TB] FAIL dis_resume_cnt: got %0d want %0d", err_cnt_o, exp_cnt); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (rd_req_o !== 1'b0 || raddr_o !== 5'd1 || err_o !== 1'b0 || err_addr_o !== 5'd0 || err_cnt_o !== 2'd0)
      $display("[TB] FAIL async_reset: rd_req %0b raddr %0d err %0b addr %0d cnt %0d want 0/1/0/0/0",
               rd_req_o, raddr_o, err_o, err_addr_o, err_cnt_o);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    cyc    = 0;
    test_reset();
    test_clean_walk();
    test_corrupt_x5();
    test_port_busy();
    test_collision();
    test_saturation();
    test_disable_in_check();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
